program_loader: RTL and testbench

- Boot-time stage directly upstream of the processor core's local memory.
- Accepts a framed byte stream from a serial receiver and assembles big-endian 16-bit words.
- Writes the words sequentially into local memory starting at address 0, holding the core in reset until the whole image has arrived and its checksum matches.
- On success it releases the core. On error it keeps the core held and flags the fault.

---
 rtl/program_loader.sv | 164 ++++++++++++++++
 tb/tb_program_loader.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed boot-image loader feeding the core's local memory
//
// Receives LEN_HI, LEN_LO, N big-endian word pairs and a mod-256 checksum byte,
// writes the words to local memory from address 0 and releases the core only
// when the checksum matches.
//
// Ports:
//   clock            system clock, rising edge
//   reset            asynchronous active-low reset
//   rx_data/rx_valid byte stream from the serial receiver
//   rx_ready         byte accepted on a rising edge where rx_valid is also high
//   restart          reload request, honoured only after a load finished or failed
//   mem_write_enable single-cycle memory write strobe
//   mem_address      word address of the write (held between writes)
//   mem_data         word to write (held between writes)
//   core_hold        processor core held in reset while high
//   load_done        image loaded and verified
//   load_error       length or checksum fault
module program_loader #(
    parameter int address_width = 12
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    input  logic                     restart,
    output logic                     mem_write_enable,
    output logic [address_width-1:0] mem_address,
    output logic [15:0]              mem_data,
    output logic                     core_hold,
    output logic                     load_done,
    output logic                     load_error
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_CHK,
        S_RUN,
        S_ERROR
    } state_t;

    // Compare width wide enough for both the 16-bit length and the counter.
    localparam int CW = (address_width + 1 > 17) ? address_width + 1 : 17;
    localparam logic [CW-1:0] MAX_LEN = CW'(1) << address_width;

    state_t                 state;
    state_t                 state_next;
    logic [15:0]            len;
    logic [7:0]             hi_byte;
    logic [7:0]             sum;
    logic [address_width:0] word_cnt;

    logic        xfer;
    logic        accepting;
    logic        restart_hit;
    logic        last_word;
    logic [15:0] len_full;

    assign xfer        = rx_valid & rx_ready;
    assign restart_hit = restart && (state == S_RUN || state == S_ERROR);
    assign len_full    = {len[15:8], rx_data};
    assign last_word   = (CW'(word_cnt) + CW'(1)) == CW'(len);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_LEN_HI;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_LEN_HI:  if (xfer) state_next = S_LEN_LO;
            S_LEN_LO: begin
                if (xfer) begin
                    if (CW'(len_full) > MAX_LEN) begin
                        state_next = S_ERROR;
                    end else if (len_full == 16'd0) begin
                        state_next = S_CHK;
                    end else begin
                        state_next = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: if (xfer) state_next = S_DATA_LO;
            S_DATA_LO: if (xfer) state_next = S_WRITE;
            S_WRITE:   state_next = last_word ? S_CHK : S_DATA_HI;
            S_CHK:     if (xfer) state_next = (rx_data == sum) ? S_RUN : S_ERROR;
            S_RUN:     if (restart_hit) state_next = S_LEN_HI;
            S_ERROR:   if (restart_hit) state_next = S_LEN_HI;
            default:   state_next = S_LEN_HI;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        accepting        = 1'b0;
        mem_write_enable = 1'b0;
        core_hold        = 1'b1;
        load_done        = 1'b0;
        load_error       = 1'b0;
        case (state)
            S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHK: accepting = 1'b1;
            S_WRITE: mem_write_enable = 1'b1;
            S_RUN: begin
                core_hold = 1'b0;
                load_done = 1'b1;
            end
            S_ERROR: load_error = 1'b1;
            default: accepting = 1'b0;
        endcase
        // Reset forces the receiver to stall even though the state already reads S_LEN_HI.
        rx_ready = accepting & reset;
    end

    // Datapath: length, checksum, word assembly and write counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            len         <= '0;
            hi_byte     <= '0;
            sum         <= '0;
            word_cnt    <= '0;
            mem_address <= '0;
            mem_data    <= '0;
        end else if (restart_hit) begin
            len         <= '0;
            hi_byte     <= '0;
            sum         <= '0;
            word_cnt    <= '0;
            mem_address <= '0;
            mem_data    <= '0;
        end else begin
            // The checksum byte itself is never folded into the sum.
            if (xfer && state != S_CHK) begin
                sum <= sum + rx_data;
            end
            case (state)
                S_LEN_HI:  if (xfer) len[15:8] <= rx_data;
                S_LEN_LO:  if (xfer) len[7:0]  <= rx_data;
                S_DATA_HI: if (xfer) hi_byte   <= rx_data;
                S_DATA_LO: begin
                    // Address and data are latched here so they are stable for
                    // the strobe cycle and then hold until the next word.
                    if (xfer) begin
                        mem_data    <= {hi_byte, rx_data};
                        mem_address <= word_cnt[address_width-1:0];
                    end
                end
                S_WRITE:   word_cnt <= word_cnt + 1'b1;
                default:   ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

    typedef logic [7:0] bytes_t[$];

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        restart;
    logic        mem_write_enable;
    logic [11:0] mem_address;
    logic [15:0] mem_data;
    logic        core_hold;
    logic        load_done;
    logic        load_error;

    int checks = 0;
    int passed = 0;

    logic [11:0] wr_addr[$];
    logic [15:0] wr_data[$];
    int   ready_bad  = 0;
    int   consec_bad = 0;
    int   late_bad   = 0;
    logic prev_we    = 1'b0;

    bytes_t      good_stream;
    logic [11:0] exp_a[3];
    logic [15:0] exp_d[3];

    always #5 clock = ~clock;

    program_loader #(.address_width(12)) dut (
        .clock            (clock),
        .reset            (reset),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .restart          (restart),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_data         (mem_data),
        .core_hold        (core_hold),
        .load_done        (load_done),
        .load_error       (load_error)
    );

    // Write log and invariant watch, sampled mid-cycle.
    always @(negedge clock) begin
        if (mem_write_enable) begin
            wr_addr.push_back(mem_address);
            wr_data.push_back(mem_data);
            if (rx_ready) ready_bad <= ready_bad + 1;
            if (prev_we) consec_bad <= consec_bad + 1;
        end
        if (mem_write_enable && (load_done || load_error)) late_bad <= late_bad + 1;
        prev_we <= mem_write_enable;
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clock);
        @(negedge clock);
        rx_data  = b;
        rx_valid = 1'b1;
        waited   = 0;
        #1;
        while (rx_ready !== 1'b1 && waited < 20) begin
            @(negedge clock);
            #1;
            waited++;
        end
        if (rx_ready !== 1'b1) begin
            checks++;
            $display("FAIL send_byte_timeout: rx_ready=%b required 1 for byte %h", rx_ready, b);
        end else begin
            @(posedge clock);
        end
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_stream(input bytes_t s, input int max_gap);
        foreach (s[i]) send_byte(s[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
    endtask

    task automatic pulse_restart();
        @(negedge clock);
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        restart  = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if ({rx_ready, core_hold, mem_write_enable, load_done, load_error} !== 5'b01000) begin
            $display("FAIL reset_ctrl: got rdy/hold/we/done/err=%b required 01000",
                     {rx_ready, core_hold, mem_write_enable, load_done, load_error});
        end else passed++;
        checks++;
        if ({mem_address, mem_data} !== 28'h0) begin
            $display("FAIL reset_mem: got addr=%h data=%h required 000/0000", mem_address, mem_data);
        end else passed++;
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (rx_ready !== 1'b1) begin
            $display("FAIL reset_release_ready: got %b required 1", rx_ready);
        end else passed++;
    endtask

    task automatic test_basic();
        clear_log();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        @(negedge clock);
        #1;
        checks++;
        if ({mem_write_enable, rx_ready, mem_address, mem_data} !== {2'b10, 12'h000, 16'h1234}) begin
            $display("FAIL basic_latency: got we=%b rdy=%b addr=%h data=%h required 1 0 000 1234",
                     mem_write_enable, rx_ready, mem_address, mem_data);
        end else passed++;
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'hC0, 0);
        @(negedge clock);
        #1;
        checks++;
        if ({load_done, core_hold, load_error} !== 3'b100) begin
            $display("FAIL basic_status: got done/hold/err=%b required 100", {load_done, core_hold, load_error});
        end else passed++;
        checks++;
        if (wr_addr.size() != 3) begin
            $display("FAIL basic_write_count: got %0d required 3", wr_addr.size());
        end else passed++;
        for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
            checks++;
            if ({wr_addr[i], wr_data[i]} !== {exp_a[i], exp_d[i]}) begin
                $display("FAIL basic_write%0d: got %h@%h required %h@%h", i, wr_data[i], wr_addr[i], exp_d[i], exp_a[i]);
            end else passed++;
        end
        checks++;
        if ({mem_address, mem_data} !== {12'h002, 16'h00FF}) begin
            $display("FAIL basic_hold_outputs: got addr=%h data=%h required 002 00ff", mem_address, mem_data);
        end else passed++;
    endtask

    task automatic test_bad_checksum();
        bytes_t s;
        pulse_restart();
        checks++;
        if ({rx_ready, load_done, core_hold, load_error} !== 4'b1010) begin
            $display("FAIL restart_from_run: got rdy/done/hold/err=%b required 1010",
                     {rx_ready, load_done, core_hold, load_error});
        end else passed++;
        clear_log();
        s = good_stream;
        s[s.size() - 1] = 8'hC1;
        send_stream(s, 0);
        @(negedge clock);
        #1;
        checks++;
        if ({load_done, core_hold, load_error} !== 3'b011) begin
            $display("FAIL badchk_status: got done/hold/err=%b required 011", {load_done, core_hold, load_error});
        end else passed++;
        checks++;
        if (wr_addr.size() != 3) begin
            $display("FAIL badchk_write_count: got %0d required 3", wr_addr.size());
        end else passed++;
    endtask

    task automatic test_zero_length();
        pulse_restart();
        clear_log();
        send_stream('{8'h00, 8'h00, 8'h00}, 0);
        @(negedge clock);
        #1;
        checks++;
        if ({load_done, core_hold, load_error} !== 3'b100) begin
            $display("FAIL zero_status: got done/hold/err=%b required 100", {load_done, core_hold, load_error});
        end else passed++;
        checks++;
        if (wr_addr.size() != 0) begin
            $display("FAIL zero_write_count: got %0d required 0", wr_addr.size());
        end else passed++;
    endtask

    task automatic test_length_overflow();
        pulse_restart();
        clear_log();
        send_byte(8'h10, 0);
        // Mid-frame restart must be ignored, so 01 still lands as LEN_LO.
        pulse_restart();
        send_byte(8'h01, 0);
        @(negedge clock);
        #1;
        checks++;
        if ({load_done, core_hold, load_error} !== 3'b011) begin
            $display("FAIL overflow_status: got done/hold/err=%b required 011", {load_done, core_hold, load_error});
        end else passed++;
        checks++;
        if (wr_addr.size() != 0) begin
            $display("FAIL overflow_write_count: got %0d required 0", wr_addr.size());
        end else passed++;
    endtask

    task automatic test_max_length();
        bytes_t s;
        int     bad_seq;
        pulse_restart();
        clear_log();
        s.push_back(8'h10);
        s.push_back(8'h00);
        for (int i = 0; i < 4096; i++) begin
            s.push_back(8'h00);
            s.push_back(8'h01);
        end
        s.push_back(8'h10);
        send_stream(s, 0);
        @(negedge clock);
        #1;
        checks++;
        if ({load_done, core_hold, load_error} !== 3'b100) begin
            $display("FAIL max_status: got done/hold/err=%b required 100", {load_done, core_hold, load_error});
        end else passed++;
        checks++;
        if (wr_addr.size() != 4096) begin
            $display("FAIL max_write_count: got %0d required 4096", wr_addr.size());
        end else passed++;
        bad_seq = 0;
        for (int i = 0; i < wr_addr.size(); i++) begin
            if (wr_addr[i] !== 12'(i) || wr_data[i] !== 16'h0001) bad_seq++;
        end
        checks++;
        if (bad_seq != 0) begin
            $display("FAIL max_sequence: got %0d bad writes required 0", bad_seq);
        end else passed++;
        checks++;
        if (wr_addr.size() > 0 && wr_addr[wr_addr.size() - 1] !== 12'hFFF) begin
            $display("FAIL max_last_addr: got %h required fff", wr_addr[wr_addr.size() - 1]);
        end else passed++;
    endtask

    task automatic test_mid_reset();
        pulse_restart();
        clear_log();
        send_stream('{8'h00, 8'h03, 8'h12, 8'h34}, 0);
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({core_hold, mem_write_enable, rx_ready, load_done, load_error} !== 5'b10000) begin
            $display("FAIL midreset_ctrl: got hold/we/rdy/done/err=%b required 10000",
                     {core_hold, mem_write_enable, rx_ready, load_done, load_error});
        end else passed++;
        @(negedge clock);
        reset = 1'b1;
        clear_log();
        send_stream(good_stream, 0);
        @(negedge clock);
        #1;
        checks++;
        if ({load_done, core_hold, load_error} !== 3'b100) begin
            $display("FAIL midreset_reload_status: got done/hold/err=%b required 100", {load_done, core_hold, load_error});
        end else passed++;
        checks++;
        if (wr_addr.size() != 3) begin
            $display("FAIL midreset_write_count: got %0d required 3", wr_addr.size());
        end else passed++;
        for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
            checks++;
            if ({wr_addr[i], wr_data[i]} !== {exp_a[i], exp_d[i]}) begin
                $display("FAIL midreset_write%0d: got %h@%h required %h@%h", i, wr_data[i], wr_addr[i], exp_d[i], exp_a[i]);
            end else passed++;
        end
    endtask

    task automatic test_restart_with_gaps();
        pulse_restart();
        send_stream('{8'h10, 8'h01}, 0);
        @(negedge clock);
        #1;
        checks++;
        if (load_error !== 1'b1) begin
            $display("FAIL gaps_enter_error: got load_error=%b required 1", load_error);
        end else passed++;
        pulse_restart();
        clear_log();
        send_stream(good_stream, 4);
        @(negedge clock);
        #1;
        checks++;
        if ({load_done, core_hold, load_error} !== 3'b100) begin
            $display("FAIL gaps_status: got done/hold/err=%b required 100", {load_done, core_hold, load_error});
        end else passed++;
        checks++;
        if (wr_addr.size() != 3) begin
            $display("FAIL gaps_write_count: got %0d required 3", wr_addr.size());
        end else passed++;
        for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
            checks++;
            if ({wr_addr[i], wr_data[i]} !== {exp_a[i], exp_d[i]}) begin
                $display("FAIL gaps_write%0d: got %h@%h required %h@%h", i, wr_data[i], wr_addr[i], exp_d[i], exp_a[i]);
            end else passed++;
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (ready_bad != 0) begin
            $display("FAIL ready_during_write: got %0d required 0", ready_bad);
        end else passed++;
        checks++;
        if (consec_bad != 0) begin
            $display("FAIL strobe_width: got %0d multi-cycle strobes required 0", consec_bad);
        end else passed++;
        checks++;
        if (late_bad != 0) begin
            $display("FAIL write_after_finish: got %0d required 0", late_bad);
        end else passed++;
    endtask

    initial begin
        good_stream = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF, 8'hC0};
        exp_a = '{12'h000, 12'h001, 12'h002};
        exp_d = '{16'h1234, 16'hABCD, 16'h00FF};
        test_reset();
        test_basic();
        test_bad_checksum();
        test_zero_length();
        test_length_overflow();
        test_max_length();
        test_mid_reset();
        test_restart_with_gaps();
        test_invariants();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
